// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one shared request/ready bus; s_valid 1 cycle after valid, ready >= 2 cycles.
// Backpressure: masters hold valid until their ready pulse; a slave that stalls TIMEOUT_CYCLES is forced to an error completion.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic          rr_q;
    logic [CW-1:0] busy_cnt;
    logic          req0, req1, win, do_grant, done_ok, done_to;

    // A requester still showing its ready pulse is finishing, not asking again.
    always_comb begin
        state_d  = state_q;
        req0     = m0_valid & ~m0_ready;
        req1     = m1_valid & ~m1_ready;
        win      = 1'b0;
        do_grant = 1'b0;
        done_ok  = 1'b0;
        done_to  = 1'b0;
        case (state_q)
            IDLE: begin
                win      = (req0 & req1) ? rr_q : req1;
                do_grant = req0 | req1;
                if (do_grant) state_d = BUSY;
            end
            BUSY: begin
                done_ok = s_ready;
                done_to = (TIMEOUT_CYCLES > 0) && !s_ready && (busy_cnt == CNT_LAST);
                if (done_ok || done_to) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_valid     <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_wstrb     <= '0;
            grant       <= 2'b00;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            timeout_err <= 1'b0;
            busy_cnt    <= '0;
            rr_q        <= 1'b0;
        end else begin
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            timeout_err <= 1'b0;
            if (do_grant) begin
                s_valid  <= 1'b1;
                grant    <= win ? 2'b10 : 2'b01;
                s_addr   <= win ? m1_addr  : m0_addr;
                s_wdata  <= win ? m1_wdata : m0_wdata;
                s_wstrb  <= win ? m1_wstrb : m0_wstrb;
                busy_cnt <= '0;
            end else if (state_q == BUSY) begin
                busy_cnt <= busy_cnt + CW'(1);
                if (done_ok || done_to) begin
                    s_valid     <= 1'b0;
                    grant       <= 2'b00;
                    timeout_err <= done_to;
                    // grant[1] identifies the owner; the other side gets priority next time
                    rr_q        <= ~grant[1];
                    if (grant[1]) begin
                        m1_ready <= 1'b1;
                        m1_rdata <= done_ok ? s_rdata : '0;
                    end else begin
                        m0_ready <= 1'b1;
                        m0_rdata <= done_ok ? s_rdata : '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed checks of mem_bus_arbiter against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid, m0_ready, m1_ready, s_valid, s_ready, timeout_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, how many bus cycles it has waited, whose turn is next.
    int          mdl_owner;
    int          mdl_age;
    int          mdl_turn;
    logic        exp_svalid, exp_to;
    logic [1:0]  exp_grant, exp_rdy;
    logic [31:0] exp_saddr, exp_swdata;
    logic [3:0]  exp_swstrb;
    logic [31:0] exp_rdata [2];

    task automatic model_reset();
        mdl_owner = -1; mdl_age = 0; mdl_turn = 0;
        exp_svalid = 0; exp_to = 0; exp_grant = 0; exp_rdy = 0;
        exp_saddr = 0; exp_swdata = 0; exp_swstrb = 0;
        exp_rdata[0] = 0; exp_rdata[1] = 0;
    endtask

    task automatic model_step();
        logic [1:0] nrdy;
        logic       nto;
        bit         c0, c1;
        int         who;
        nrdy = 2'b00; nto = 1'b0; who = -1;
        if (mdl_owner < 0) begin
            c0 = m0_valid && !exp_rdy[0];
            c1 = m1_valid && !exp_rdy[1];
            if (c0 && c1) who = mdl_turn;
            else if (c0)  who = 0;
            else if (c1)  who = 1;
            if (who >= 0) begin
                mdl_owner  = who;
                mdl_age    = 1;
                exp_svalid = 1'b1;
                exp_grant  = (who == 0) ? 2'b01 : 2'b10;
                exp_saddr  = (who == 0) ? m0_addr  : m1_addr;
                exp_swdata = (who == 0) ? m0_wdata : m1_wdata;
                exp_swstrb = (who == 0) ? m0_wstrb : m1_wstrb;
            end
        end else if (s_ready || (TO > 0 && mdl_age == TO)) begin
            nrdy[mdl_owner]      = 1'b1;
            exp_rdata[mdl_owner] = s_ready ? s_rdata : 32'h0;
            nto        = !s_ready;
            mdl_turn   = 1 - mdl_owner;
            mdl_owner  = -1;
            exp_svalid = 1'b0;
            exp_grant  = 2'b00;
        end else begin
            mdl_age++;
        end
        exp_rdy = nrdy;
        exp_to  = nto;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else         model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("s_valid",     32'(s_valid),     32'(exp_svalid));
                chk("grant",       32'(grant),       32'(exp_grant));
                chk("s_addr",      s_addr,           exp_saddr);
                chk("s_wdata",     s_wdata,          exp_swdata);
                chk("s_wstrb",     32'(s_wstrb),     32'(exp_swstrb));
                chk("m0_ready",    32'(m0_ready),    32'(exp_rdy[0]));
                chk("m1_ready",    32'(m1_ready),    32'(exp_rdy[1]));
                chk("m0_rdata",    m0_rdata,         exp_rdata[0]);
                chk("m1_rdata",    m1_rdata,         exp_rdata[1]);
                chk("timeout_err", 32'(timeout_err), 32'(exp_to));
                chk("both_ready",  32'(m0_ready & m1_ready), 32'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int cnt;
        int prev;
        int ngrants;
        resetn = 1'b0;
        clear_inputs();
        chk_on = 1'b1;

        // Reset values and single m0 read
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_svalid", 32'(s_valid), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        m0_valid = 1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
        @(negedge clk);
        chk("rd_svalid", 32'(s_valid), 32'h1);
        chk("rd_saddr", s_addr, 32'h0000_0010);
        chk("rd_grant", 32'(grant), 32'h1);
        s_ready = 1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_m0_ready", 32'(m0_ready), 32'h1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_valid = 0; s_ready = 0;
        @(negedge clk);
        chk("rd_ready_pulse", 32'(m0_ready), 32'h0);

        // Simultaneous requests from reset: 01, 00, 10
        do_reset();
        s_ready = 1; s_rdata = 32'h1234_5678;
        m0_valid = 1; m0_addr = 32'h100;
        m1_valid = 1; m1_addr = 32'h200; m1_wdata = 32'hAAAA_5555; m1_wstrb = 4'h3;
        @(negedge clk);
        chk("both_g1", 32'(grant), 32'h1);
        @(negedge clk);
        chk("both_g2", 32'(grant), 32'h0);
        chk("both_m0rdy", 32'(m0_ready), 32'h1);
        m0_valid = 0;
        @(negedge clk);
        chk("both_g3", 32'(grant), 32'h2);
        chk("both_wstrb", 32'(s_wstrb), 32'h3);
        chk("both_wdata", s_wdata, 32'hAAAA_5555);
        @(negedge clk);
        chk("both_m1rdata", m1_rdata, 32'h1234_5678);
        m1_valid = 0; s_ready = 0;
        @(negedge clk);

        // Continuous re-requests alternate strictly
        m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'h0BAD_F00D;
        prev = 1; ngrants = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (grant != 2'b00) begin
                chk("alt_grant", 32'(grant), (prev == 0) ? 32'h2 : 32'h1);
                prev = (grant == 2'b01) ? 0 : 1;
                ngrants++;
            end
        end
        chk("alt_count", ngrants, 8);
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        @(negedge clk);

        // Timeout on an m1 write
        m1_valid = 1; m1_wstrb = 4'hF; m1_addr = 32'h300; m1_wdata = 32'hFFFF_0000;
        cnt = 0;
        @(negedge clk);
        while (s_valid && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_svalid_cycles", cnt, TO);
        chk("to_m1_ready", 32'(m1_ready), 32'h1);
        chk("to_err", 32'(timeout_err), 32'h1);
        chk("to_m1_rdata", m1_rdata, 32'h0);
        m1_valid = 0;
        @(negedge clk);
        chk("to_err_pulse", 32'(timeout_err), 32'h0);

        // s_ready on the timeout cycle wins
        m0_valid = 1; m0_addr = 32'h400; m0_wstrb = 4'h0; s_ready = 0; s_rdata = 32'hCAFE_F00D;
        repeat (4) @(negedge clk);
        chk("edge_svalid", 32'(s_valid), 32'h1);
        s_ready = 1;
        @(negedge clk);
        chk("edge_m0_ready", 32'(m0_ready), 32'h1);
        chk("edge_m0_rdata", m0_rdata, 32'hCAFE_F00D);
        chk("edge_no_err", 32'(timeout_err), 32'h0);
        m0_valid = 0; s_ready = 0;
        @(negedge clk);

        // Reset in the middle of a transaction
        m1_valid = 1; m1_addr = 32'h500; m1_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mr_svalid", 32'(s_valid), 32'h0);
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_saddr", s_addr, 32'h0);
        chk("mr_m0_rdata", m0_rdata, 32'h0);
        chk("mr_m1_ready", 32'(m1_ready), 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("mr_regrant", 32'(grant), 32'h2);
        chk("mr_regrant_addr", s_addr, 32'h500);
        s_ready = 1; s_rdata = 32'h600D_F00D;
        @(negedge clk);
        chk("mr_m1_rdata", m1_rdata, 32'h600D_F00D);
        m1_valid = 0; s_ready = 0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (m0_valid && m0_ready) begin
                if ($urandom_range(0, 1) == 1) begin
                    m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
                end else begin
                    m0_valid = 0;
                end
            end else if (!m0_valid && $urandom_range(0, 2) == 0) begin
                m0_valid = 1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
            end
            if (m1_valid && m1_ready) begin
                if ($urandom_range(0, 1) == 1) begin
                    m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
                end else begin
                    m1_valid = 0;
                end
            end else if (!m1_valid && $urandom_range(0, 2) == 0) begin
                m1_valid = 1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
            end
            s_ready = ($urandom_range(0, 9) < 4);
            s_rdata = $urandom;
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        repeat (10) @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
